// File: rtl/exit_rd_arbiter_if.sv
// exit_rd_arbiter_if: AXI read-path bundle between NUM_REQ requesters (s_*) and the exit pipeline (m_*)
// slave: arbiter view (drives s_arready, s_r*, m_ar*, m_rready, rid_err); master: mirror for the environment
interface exit_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 33,
  parameter int DATA_W = 256,
  parameter int IDX_W = 3
);
  logic [NUM_REQ-1:0] s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM_REQ*ADDR_W-1:0] s_araddr;
  logic [NUM_REQ*8-1:0] s_arlen;
  logic [DATA_W-1:0] s_rdata, m_rdata;
  logic [1:0] s_rresp, m_rresp;
  logic s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, rid_err;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [IDX_W-1:0] m_arid, m_rid;
  modport slave (
    input s_arvalid, s_araddr, s_arlen, s_rready, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, m_arvalid, m_araddr, m_arlen, m_arid, m_rready, rid_err
  );
  modport master (
    output s_arvalid, s_araddr, s_arlen, s_rready, m_arready, m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
    input s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, m_arvalid, m_araddr, m_arlen, m_arid, m_rready, rid_err
  );
endinterface

// File: rtl/exit_rd_arbiter.sv
// exit_rd_arbiter: round-robin AR arbiter with R routing by id and per-requester in-flight burst caps
// aclk/areset: clock, async active-high reset; bus: exit_rd_arbiter_if.slave (requester AR/R + exit pipeline AR/R)
module exit_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 33,
  parameter int DATA_W = 256,
  parameter int IDX_W = 3,
  parameter int MAX_OUT = 8
) (
  input logic aclk,
  input logic areset,
  exit_rd_arbiter_if.slave bus
);
  localparam int NP = 2**IDX_W;
  localparam logic [3:0] LP_MAX = 4'(MAX_OUT);
  localparam logic [IDX_W:0] LP_NUM = (IDX_W+1)'(NUM_REQ);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_ptr, r_id, w_win;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [7:0] r_len, w_len;
  logic [3:0] r_cnt [NUM_REQ];
  logic r_err;
  logic [NP-1:0] w_elig, w_rrdy;
  logic [NUM_REQ-1:0] w_inc, w_dec;
  logic w_any, w_grant, w_rid_ok, w_rhs;
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) w_elig[i] = bus.s_arvalid[i] & (r_cnt[i] < LP_MAX);
  end
  // scanning from the farthest slot back to rr_ptr+1 leaves the nearest eligible one as winner
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (w_elig[IDX_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_win = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
  end
  always_comb begin
    w_addr = '0;
    w_len = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_win == IDX_W'(i)) begin
        w_addr = bus.s_araddr[i*ADDR_W +: ADDR_W];
        w_len = bus.s_arlen[i*8 +: 8];
      end
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = (r_state == IDLE) ? (w_any ? ISSUE : IDLE) : (bus.m_arready ? IDLE : ISSUE);
  always_comb begin
    w_grant = (r_state == IDLE) & w_any;
    w_inc = w_grant ? NUM_REQ'(1) << w_win : '0;
    bus.s_arready = w_inc;
    bus.m_arvalid = r_state == ISSUE;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
    end else if (w_grant) begin
      r_ptr <= w_win;
      r_id <= w_win;
      r_addr <= w_addr;
      r_len <= w_len;
    end
  assign bus.m_araddr = r_addr;
  assign bus.m_arlen = r_len;
  assign bus.m_arid = r_id;
  assign w_rid_ok = {1'b0, bus.m_rid} < LP_NUM;
  assign w_rrdy = NP'(bus.s_rready);
  // out-of-range ids are accepted and dropped so the pipeline never stalls on them
  assign bus.m_rready = w_rid_ok ? w_rrdy[bus.m_rid] : 1'b1;
  assign bus.s_rvalid = w_rid_ok ? NUM_REQ'(bus.m_rvalid) << bus.m_rid : '0;
  assign bus.s_rdata = bus.m_rdata;
  assign bus.s_rresp = bus.m_rresp;
  assign bus.s_rlast = bus.m_rlast;
  assign w_rhs = bus.m_rvalid & bus.m_rready & bus.m_rlast & w_rid_ok;
  assign w_dec = w_rhs ? NUM_REQ'(1) << bus.m_rid : '0;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_inc[i] & ~w_dec[i]) r_cnt[i] <= r_cnt[i] + 4'd1;
        else if (w_dec[i] & ~w_inc[i] & (|r_cnt[i])) r_cnt[i] <= r_cnt[i] - 4'd1;
    end
  always_ff @(posedge aclk or posedge areset)
    if (areset) r_err <= 1'b0;
    else if (bus.m_rvalid & ~w_rid_ok) r_err <= 1'b1;
  assign bus.rid_err = r_err;
endmodule
